// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch / branch decode unit.
// ST_ERR and the watchdog counter width exist only when IMEM_TIMEOUT_EN is defined.
package instr_fetch_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned COND_ADDR_W = 19;
  localparam int unsigned BR_ADDR_W   = 26;
  localparam int unsigned TIMEOUT     = 16;
`ifdef IMEM_TIMEOUT_EN
  localparam int unsigned TMO_CNT_W   = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2
`ifdef IMEM_TIMEOUT_EN
    , ST_ERR = 2'd3
`endif
  } state_e;

  // Opcode fields: B uses [31:26], B.cond and CBZ use [31:24]
  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [7:0] OP_BCOND = 8'b01010100;
  localparam logic [7:0] OP_CBZ   = 8'b10110100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory req/ack bus between the fetch unit (master) and imem (slave).
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/branch_cond_eval.sv
// B.cond evaluation: ARM condition field against the registered N/Z/V/C flags.
module branch_cond_eval
  import instr_fetch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       flag_neg,
  input  logic       flag_zero,
  input  logic       flag_ovfl,
  input  logic       flag_cout,
  output logic       taken
);

  logic ge;
  logic hi;

  assign ge = (flag_neg == flag_ovfl);
  assign hi = flag_cout && !flag_zero;

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = flag_zero;
      COND_NE: taken = !flag_zero;
      COND_HS: taken = flag_cout;
      COND_LO: taken = !flag_cout;
      COND_MI: taken = flag_neg;
      COND_PL: taken = !flag_neg;
      COND_VS: taken = flag_ovfl;
      COND_VC: taken = !flag_ovfl;
      COND_HI: taken = hi;
      COND_LS: taken = !hi;
      COND_GE: taken = ge;
      COND_LT: taken = !ge;
      COND_GT: taken = !flag_zero && ge;
      COND_LE: taken = !(!flag_zero && ge);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch and branch decode: fetches program_index over req/ack, holds the word,
// drives the PC branch controls and pc_en. Define IMEM_TIMEOUT_EN for the REQ watchdog.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      program_index,
  instr_fetch_if.master          imem,
  input  logic                   stall,
  input  logic                   flag_neg,
  input  logic                   flag_zero,
  input  logic                   flag_ovfl,
  input  logic                   flag_cout,
  input  logic                   rt_zero,
  output logic [INSTR_W-1:0]     instruction,
  output logic                   instr_valid,
  output logic                   pc_en,
  output logic [COND_ADDR_W-1:0] cond_addr,
  output logic [BR_ADDR_W-1:0]   br_addr,
  output logic                   uncondbr,
  output logic                   br_taken,
  output logic                   fetch_err
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               out_live;
  logic               bcond_taken;

`ifdef IMEM_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 fetch_err_q, fetch_err_d;
`endif

  // Next state; an ack on the final timeout cycle still wins over the error
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
`ifdef IMEM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
`ifdef IMEM_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_REQ: begin
        if (imem.imem_ack) begin
          state_d = ST_ISSUE;
          instr_d = imem.imem_rdata;
        end
`ifdef IMEM_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_CNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_ERR;
          fetch_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
        end
`endif
      end
      ST_ISSUE: begin
        if (!stall) begin
          state_d = ST_REQ;
`ifdef IMEM_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
`ifdef IMEM_TIMEOUT_EN
      ST_ERR: state_d = ST_ERR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
`ifdef IMEM_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
`ifdef IMEM_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  // Reset forces every output low in the same cycle it is asserted
`ifdef IMEM_TIMEOUT_EN
  assign out_live  = !reset && (state_q != ST_ERR);
  assign fetch_err = !reset && fetch_err_q;
`else
  assign out_live  = !reset;
  assign fetch_err = 1'b0;
`endif

  assign imem.imem_req  = out_live && (state_q == ST_REQ);
  assign imem.imem_addr = imem.imem_req ? program_index : '0;
  assign instr_valid    = out_live && (state_q == ST_ISSUE);
  assign pc_en          = instr_valid && !stall;
  assign instruction    = out_live ? instr_q : '0;
  assign cond_addr      = instruction[23:5];
  assign br_addr        = instruction[25:0];

  branch_cond_eval u_cond (
    .cond      (instruction[3:0]),
    .flag_neg  (flag_neg),
    .flag_zero (flag_zero),
    .flag_ovfl (flag_ovfl),
    .flag_cout (flag_cout),
    .taken     (bcond_taken)
  );

  always_comb begin
    uncondbr = 1'b0;
    br_taken = 1'b0;
    if (instr_valid) begin
      if (instruction[31:26] == OP_B) begin
        uncondbr = 1'b1;
        br_taken = 1'b1;
      end else if (instruction[31:24] == OP_CBZ) begin
        br_taken = rt_zero;
      end else if (instruction[31:24] == OP_BCOND) begin
        br_taken = bcond_taken;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: randomized imem latency, stalls and flags, with a
// behavioural branch model; extra timeout checks when IMEM_TIMEOUT_EN is defined.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] program_index = '0;
  logic        stall = 1'b0;
  logic        flag_neg = 1'b0, flag_zero = 1'b0, flag_ovfl = 1'b0, flag_cout = 1'b0;
  logic        rt_zero = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid, pc_en, uncondbr, br_taken, fetch_err;
  logic [18:0] cond_addr;
  logic [25:0] br_addr;

  instr_fetch_if imem_bus();

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .program_index (program_index),
    .imem          (imem_bus.master),
    .stall         (stall),
    .flag_neg      (flag_neg),
    .flag_zero     (flag_zero),
    .flag_ovfl     (flag_ovfl),
    .flag_cout     (flag_cout),
    .rt_zero       (rt_zero),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc_en         (pc_en),
    .cond_addr     (cond_addr),
    .br_addr       (br_addr),
    .uncondbr      (uncondbr),
    .br_taken      (br_taken),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int          n_consumed = 0;
  int          n_applied = 0;
  int          wait_cnt = 1;
  int          hold = 0;
  int          hold_len = 0;
  int          dir_idx = 0;
  int          idle_run = 0;
  int          tries = 0;
  bit          mon_en = 1'b0;
  bit          rst_prev = 1'b0, rst_prev2 = 1'b0, ack_prev = 1'b0, pcen_prev = 1'b0;
  logic [31:0] dir_words [4] = '{32'h8B020020, 32'h14000010, 32'h54000081, 32'hB4000060};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ARM condition codes come in complementary pairs: even code tests, odd code inverts
  function automatic bit cond_holds(input logic [3:0] cc, input bit n, input bit z,
                                    input bit v, input bit c);
    bit base = 1'b0;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  // Expected {uncondbr, br_taken} for an issued word under the current flag inputs
  function automatic logic [1:0] ref_branch(input logic [31:0] w);
    logic [7:0] op = w[31:24];
    if (w[31:26] == 6'b000101) return 2'b11;
    if (op == 8'hB4) return {1'b0, rt_zero};
    if (op == 8'h54) return {1'b0, cond_holds(w[3:0], flag_neg, flag_zero, flag_ovfl, flag_cout)};
    return 2'b00;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 4))
      0: return {6'b000101, r[25:0]};
      1: return {8'h54, r[23:0]};
      2: return {8'hB4, r[23:0]};
      3: return {8'hB5, r[23:0]};
      default: return r;
    endcase
  endfunction

  // Per-cycle stimulus, applied just after the rising edge
  task automatic drive_cycle();
    logic [31:0] w;
    @(posedge clk); #1;
    if (n_consumed != n_applied) begin
      program_index = program_index + 64'd4;
      n_applied = n_consumed;
    end
    {flag_neg, flag_zero, flag_ovfl, flag_cout} = 4'($urandom);
    rt_zero = 1'($urandom);
    stall = ($urandom_range(0, 2) == 0);
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = $urandom;
    if (imem_bus.imem_req) begin
      if (wait_cnt == 0) begin
        hold = 0;
        hold_len = 0;
        if (dir_idx < 4) begin
          w = dir_words[dir_idx];
          dir_idx++;
          if (w == 32'hB4000060) hold_len = 3;
          if (w == 32'h54000081) hold_len = 1;
        end else begin
          w = rand_word();
        end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = w;
        exp_q.push_back(w);
        wait_cnt = $urandom_range(0, 3);
      end else begin
        wait_cnt--;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      imem_bus.imem_ack = 1'b1;
    end
    if (instr_valid && hold_len > 0) begin
      stall = (hold < hold_len);
      rt_zero = 1'b1;
      flag_zero = (hold == 0);
      hold++;
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (reset || rst_prev) begin
        idle_run = 0;
        chk("rst_req", 64'(imem_bus.imem_req), 64'd0);
        chk("rst_addr", imem_bus.imem_addr, 64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_fields", 64'({cond_addr, br_addr}), 64'd0);
        chk("rst_ctl", 64'({instr_valid, pc_en, uncondbr, br_taken, fetch_err}), 64'd0);
      end else begin
        if (rst_prev2) chk("req_after_reset", 64'(imem_bus.imem_req), 64'd1);
        if (ack_prev) chk("valid_after_ack", 64'(instr_valid), 64'd1);
        if (pcen_prev) chk("req_after_pc_en", 64'(imem_bus.imem_req), 64'd1);
        chk("fetch_err_low", 64'(fetch_err), 64'd0);
        if (imem_bus.imem_req) chk("imem_addr", imem_bus.imem_addr, program_index);
        if (instr_valid) begin
          idle_run = 0;
          chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            chk("instruction", 64'(instruction), 64'(exp_q[0]));
            chk("cond_addr", 64'(cond_addr), 64'(exp_q[0][23:5]));
            chk("br_addr", 64'(br_addr), 64'(exp_q[0][25:0]));
            chk("branch_ctl", 64'({uncondbr, br_taken}), 64'(ref_branch(exp_q[0])));
            chk("pc_en", 64'(pc_en), 64'(!stall));
            if (pc_en) begin
              void'(exp_q.pop_front());
              n_consumed++;
            end
          end
        end else begin
          idle_run++;
          chk("idle_ctl", 64'({pc_en, uncondbr, br_taken}), 64'd0);
          chk("issue_watchdog", 64'(idle_run > 40), 64'd0);
          if (idle_run > 40) idle_run = 0;
        end
      end
      rst_prev2 = rst_prev;
      rst_prev  = reset;
      ack_prev  = imem_bus.imem_ack && imem_bus.imem_req;
      pcen_prev = pc_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    repeat (700) drive_cycle();

    // Reset coinciding with an ack must discard the returned word
    tries = 0;
    drive_cycle();
    while (!imem_bus.imem_req && tries < 20) begin
      drive_cycle();
      tries++;
    end
    chk("reach_req", 64'(imem_bus.imem_req), 64'd1);
    exp_q.delete();
    hold_len = 0;
    reset = 1'b1;
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h14000010;
    program_index = '0;
    n_applied = n_consumed;
    @(posedge clk); #1;
    reset = 1'b0;
    imem_bus.imem_ack = 1'b0;
    chk("rst_ack_valid", 64'(instr_valid), 64'd0);
    chk("rst_ack_instr", 64'(instruction), 64'd0);
    wait_cnt = 0;

    repeat (80) drive_cycle();
    chk("throughput", 64'(n_consumed >= 100), 64'd1);

`ifdef IMEM_TIMEOUT_EN
    mon_en = 1'b0;
    imem_bus.imem_ack = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("tmo_req_held", 64'(imem_bus.imem_req), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("tmo_err", 64'(fetch_err), 64'd1);
      chk("tmo_req_off", 64'({imem_bus.imem_req, instr_valid, pc_en}), 64'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("tmo_err_cleared", 64'(fetch_err), 64'd0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("tmo_req_wait", 64'(imem_bus.imem_req), 64'd1);
    end
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h14000010;
    @(posedge clk); #1;
    imem_bus.imem_ack = 1'b0;
    chk("tmo_late_ack_valid", 64'(instr_valid), 64'd1);
    chk("tmo_late_ack_err", 64'(fetch_err), 64'd0);
    chk("tmo_late_ack_instr", 64'(instruction), 64'h14000010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
